// File: rtl/bus_fifo_out_if.sv
// Stream and FIFO-side signals of bus_fifo_out, grouped for port connection.
// master is the drainer's view, slave is the FIFO/host side.
interface bus_fifo_out_if #(
  parameter int unsigned CNTW = 16
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 16;

  logic [DATA_W-1:0] fifo_data_i;
  logic              fifo_pktend_i;
  logic              fifo_empty_i;
  logic              fifo_re_o;
  logic [DATA_W-1:0] data_o;
  logic              last_o;
  logic              valid_o;
  logic              ready_i;
  logic              busy_o;
  logic [CNTW-1:0]   pkt_cnt_o;
  logic [WCNT_W-1:0] wcnt_o;

  modport master (
    input  fifo_data_i, fifo_pktend_i, fifo_empty_i, ready_i,
    output fifo_re_o, data_o, last_o, valid_o, busy_o, pkt_cnt_o, wcnt_o
  );

  modport slave (
    output fifo_data_i, fifo_pktend_i, fifo_empty_i, ready_i,
    input  fifo_re_o, data_o, last_o, valid_o, busy_o, pkt_cnt_o, wcnt_o
  );
endinterface

// File: rtl/bus_fifo_out.sv
// Drains a non-showahead packet FIFO into a valid/ready/last stream through a
// 2-entry skid buffer, splitting packets at MAXLEN words and counting packets.
module bus_fifo_out #(
  parameter int unsigned MAXLEN = 256,
  parameter int unsigned CNTW   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bus_fifo_out_if.master bus
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 16;
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(MAXLEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BODY = 1'b1;

  typedef struct packed {
    logic              pktend;
    logic [DATA_W-1:0] data;
  } word_t;

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  word_t             tail_q, tail_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNTW-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [0:0]        state_q, state_d;
  logic              busy_q, busy_d;

  logic        valid_c;
  logic        pop_c;
  logic        fifo_re_c;
  logic [2:0]  occ_pred_c;
  word_t       in_word_c;
  logic        head_load_c;
  word_t       head_src_c;

  // Read request looks at the occupancy the buffer will have after this edge.
  always_comb begin
    valid_c    = valid_q && !rst_i;
    pop_c      = valid_c && bus.ready_i;
    in_word_c  = {bus.fifo_pktend_i, bus.fifo_data_i};
    occ_pred_c = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
    fifo_re_c  = !rst_i && !bus.fifo_empty_i && (occ_pred_c < 3'd2);
  end

  always_comb begin
    occ_d       = occ_pred_c[1:0];
    inflight_d  = fifo_re_c;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    tail_d      = tail_q;
    wcnt_d      = wcnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    state_d     = state_q;
    busy_d      = busy_q;
    head_load_c = 1'b0;
    head_src_c  = in_word_c;

    if (pop_c) begin
      if (last_q) begin
        wcnt_d    = '0;
        pkt_cnt_d = pkt_cnt_q + CNTW'(1);
        state_d   = S_IDLE;
      end else begin
        wcnt_d    = wcnt_q + WCNT_W'(1);
        state_d   = S_BODY;
      end
    end

    // Head is refilled from the FIFO word or the tail entry; tail only holds overflow.
    case (occ_q)
      2'd0: begin
        if (inflight_q) head_load_c = 1'b1;
      end
      2'd1: begin
        if (pop_c && inflight_q) head_load_c = 1'b1;
        else if (!pop_c && inflight_q) tail_d = in_word_c;
      end
      default: begin
        if (pop_c) begin
          head_load_c = 1'b1;
          head_src_c  = tail_q;
        end
        if (inflight_q) tail_d = in_word_c;
      end
    endcase

    // Last is decided on entry to the head, using the post-pop word count.
    if (head_load_c) begin
      data_d = head_src_c.data;
      last_d = head_src_c.pktend || (wcnt_d == LAST_IDX);
    end

    valid_d = (occ_d != 2'd0);
    busy_d  = (state_d == S_BODY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      data_q     <= '0;
      tail_q     <= '0;
      wcnt_q     <= '0;
      pkt_cnt_q  <= '0;
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      tail_q     <= tail_d;
      wcnt_q     <= wcnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.fifo_re_o = fifo_re_c;
  assign bus.valid_o   = valid_c;
  assign bus.data_o    = data_q;
  assign bus.last_o    = last_q;
  assign bus.busy_o    = busy_q;
  assign bus.pkt_cnt_o = pkt_cnt_q;
  assign bus.wcnt_o    = wcnt_q;
endmodule

// File: tb/tb_bus_fifo_out.sv
// Bench for bus_fifo_out: two instances (MAXLEN 256 and MAXLEN 8 / 3-bit packet
// counter) share one FIFO model and are checked against a packet-level model.
module tb_bus_fifo_out;
  localparam int unsigned ML_A  = 256;
  localparam int unsigned ML_B  = 8;
  localparam int unsigned CNT_B = 3;

  logic        clk;
  logic        rst;
  logic [31:0] fifo_data;
  logic        fifo_pkt;
  logic        fifo_empty;
  logic        ready;

  bus_fifo_out_if #(.CNTW(16))    if_a ();
  bus_fifo_out_if #(.CNTW(CNT_B)) if_b ();

  assign if_a.fifo_data_i   = fifo_data;
  assign if_a.fifo_pktend_i = fifo_pkt;
  assign if_a.fifo_empty_i  = fifo_empty;
  assign if_a.ready_i       = ready;
  assign if_b.fifo_data_i   = fifo_data;
  assign if_b.fifo_pktend_i = fifo_pkt;
  assign if_b.fifo_empty_i  = fifo_empty;
  assign if_b.ready_i       = ready;

  bus_fifo_out #(.MAXLEN(ML_A), .CNTW(16))    dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  bus_fifo_out #(.MAXLEN(ML_B), .CNTW(CNT_B)) dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned nwords;
    int unsigned split;
    int unsigned gap;
    int unsigned rdy_pct;
    int unsigned lasts_a;
    int unsigned lasts_b;
    logic [31:0] base;
  } vec_t;

  int          tests;
  int          fails;
  logic [32:0] fifo_q[$];
  logic [32:0] exp_q[$];
  int          outf;
  int unsigned wa, wb, pa, pb;
  int unsigned lasts_a, lasts_b;
  int          cyc, first_pop, last_pop, total_pops;
  logic        stall_prev;
  logic [31:0] prev_data_a, prev_data_b;
  logic        prev_last_a, prev_last_b;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d, input logic p);
    fifo_q.push_back({p, d});
    exp_q.push_back({p, d});
    fifo_empty = 1'b0;
  endtask

  task automatic model_clear();
    fifo_q.delete();
    exp_q.delete();
    outf = 0;
    wa = 0; wb = 0; pa = 0; pb = 0;
    stall_prev = 1'b0;
  endtask

  // One clock: checks before the edge, FIFO model update after it; returns at negedge.
  task automatic step();
    logic        rp, re, va, pop, exp_re, la, lb;
    logic [32:0] w;
    #1;
    rp  = rst;
    re  = if_a.fifo_re_o;
    va  = if_a.valid_o;
    pop = va && ready && !rp;
    if (rp) begin
      chk("rst_re", re, 1'b0);
      chk("rst_valid", va, 1'b0);
    end else begin
      exp_re = !fifo_empty && ((outf - int'(pop)) < 2);
      chk("re_empty", re && fifo_empty, 1'b0);
      chk("re_eager", re, exp_re);
      chk("re_ab", if_b.fifo_re_o, re);
      chk("valid_ab", if_b.valid_o, va);
      chk("buf_occ", outf <= 2, 1'b1);
      chk("wcnt_a", if_a.wcnt_o, wa);
      chk("pkt_a", if_a.pkt_cnt_o, pa);
      chk("busy_a", if_a.busy_o, wa != 0);
      chk("wcnt_b", if_b.wcnt_o, wb);
      chk("pkt_b", if_b.pkt_cnt_o, pb);
      chk("busy_b", if_b.busy_o, wb != 0);
      if (stall_prev) begin
        chk("stall_valid", va, 1'b1);
        chk("stall_data_a", if_a.data_o, prev_data_a);
        chk("stall_last_a", if_a.last_o, prev_last_a);
        chk("stall_data_b", if_b.data_o, prev_data_b);
        chk("stall_last_b", if_b.last_o, prev_last_b);
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1'b1, 1'b0);
        end else begin
          w  = exp_q.pop_front();
          la = w[32] || (wa == ML_A - 1);
          lb = w[32] || (wb == ML_B - 1);
          chk("data_a", if_a.data_o, w[31:0]);
          chk("last_a", if_a.last_o, la);
          chk("data_b", if_b.data_o, w[31:0]);
          chk("last_b", if_b.last_o, lb);
          if (la) begin wa = 0; pa = (pa + 1) % 65536; end else wa++;
          if (lb) begin wb = 0; pb = (pb + 1) % (2 ** CNT_B); end else wb++;
          lasts_a += int'(if_a.last_o);
          lasts_b += int'(if_b.last_o);
          if (first_pop < 0) first_pop = cyc;
          last_pop = cyc;
          total_pops++;
        end
      end
      stall_prev  = va && !ready;
      prev_data_a = if_a.data_o;
      prev_last_a = if_a.last_o;
      prev_data_b = if_b.data_o;
      prev_last_b = if_b.last_o;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rp) begin
      model_clear();
    end else begin
      if (re && fifo_q.size() != 0) begin
        w         = fifo_q.pop_front();
        fifo_data = w[31:0];
        fifo_pkt  = w[32];
      end
      outf = outf + int'(re) - int'(pop);
    end
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic drain(input int unsigned pct);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (fifo_q.size() == 0 && outf == 0 && !if_a.valid_o) begin
        done = 1'b1;
        break;
      end
      ready = ($urandom_range(99) < pct);
      step();
    end
    chk("drain_timeout", done, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int unsigned nfirst, pb0;
    lasts_a   = 0;
    lasts_b   = 0;
    first_pop = -1;
    last_pop  = -1;
    pb0       = pb;
    nfirst    = (v.split != 0) ? v.split : v.nwords;
    for (int i = 0; i < int'(nfirst); i++)
      write_word(v.base + 32'(i), i == int'(v.nwords) - 1);
    drain(v.rdy_pct);
    if (v.split != 0) begin
      for (int g = 0; g < int'(v.gap); g++) begin
        ready = 1'b1;
        step();
        chk($sformatf("v%0d_gap_valid", idx), if_a.valid_o, 1'b0);
        chk($sformatf("v%0d_gap_busy", idx), if_a.busy_o, 1'b1);
      end
      for (int i = int'(nfirst); i < int'(v.nwords); i++)
        write_word(v.base + 32'(i), i == int'(v.nwords) - 1);
      drain(v.rdy_pct);
    end
    chk($sformatf("v%0d_lasts_a", idx), lasts_a, v.lasts_a);
    chk($sformatf("v%0d_lasts_b", idx), lasts_b, v.lasts_b);
    chk($sformatf("v%0d_wcnt_end", idx), if_a.wcnt_o, 16'd0);
    chk($sformatf("v%0d_pkt_b", idx), if_b.pkt_cnt_o, (pb0 + v.lasts_b) % (2 ** CNT_B));
    if (v.rdy_pct == 100 && v.split == 0)
      chk($sformatf("v%0d_span", idx), last_pop - first_pop + 1, v.nwords);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, if_a.valid_o, 1'b0);
    chk({tag, "_last"},  if_a.last_o, 1'b0);
    chk({tag, "_data"},  if_a.data_o, 32'd0);
    chk({tag, "_busy"},  if_a.busy_o, 1'b0);
    chk({tag, "_pkt"},   if_a.pkt_cnt_o, 16'd0);
    chk({tag, "_wcnt"},  if_a.wcnt_o, 16'd0);
    chk({tag, "_re"},    if_a.fifo_re_o, 1'b0);
    chk({tag, "_pkt_b"}, if_b.pkt_cnt_o, 3'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic found;
    vecs[0] = '{64, 0, 0, 100, 1, 8, 32'h0000_0000};
    vecs[1] = '{64, 0, 0,  50, 1, 8, 32'h0000_0000};
    vecs[2] = '{20, 0, 0, 100, 1, 3, 32'h0000_1000};
    vecs[3] = '{ 8, 0, 0, 100, 1, 1, 32'h0000_2000};
    vecs[4] = '{ 8, 5, 10, 100, 1, 1, 32'h0000_3000};
    vecs[5] = '{ 9, 0, 0,  70, 1, 2, 32'h0000_4000};
    vecs[6] = '{ 1, 0, 0, 100, 1, 1, 32'h0000_5000};
    vecs[7] = '{16, 0, 0, 100, 1, 2, 32'h0000_6000};

    tests = 0; fails = 0; cyc = 0; total_pops = 0;
    first_pop = -1; last_pop = -1; lasts_a = 0; lasts_b = 0;
    prev_data_a = '0; prev_data_b = '0; prev_last_a = 1'b0; prev_last_b = 1'b0;
    rst = 1'b1; ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0; fifo_pkt = 1'b0;
    model_clear();

    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Single word: valid two cycles after empty falls, one-word packet.
    ready = 1'b1;
    write_word(32'hDEAD_BEEF, 1'b1);
    step();
    chk("sw_t1_valid", if_a.valid_o, 1'b0);
    step();
    chk("sw_valid", if_a.valid_o, 1'b1);
    chk("sw_data", if_a.data_o, 32'hDEAD_BEEF);
    chk("sw_last", if_a.last_o, 1'b1);
    chk("sw_busy", if_a.busy_o, 1'b0);
    step();
    chk("sw_pkt", if_a.pkt_cnt_o, 16'd1);
    chk("sw_wcnt", if_a.wcnt_o, 16'd0);
    chk("sw_busy_after", if_a.busy_o, 1'b0);
    chk("sw_valid_after", if_a.valid_o, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset mid-packet with a FIFO word in flight.
    ready = 1'b1;
    for (int i = 0; i < 10; i++) write_word(32'h100 + 32'(i), i == 9);
    found = 1'b0;
    begin
      int pops0;
      pops0 = total_pops;
      for (int k = 0; k < 50; k++) begin
        if (total_pops - pops0 >= 3 && if_a.fifo_re_o) begin
          found = 1'b1;
          break;
        end
        step();
      end
    end
    chk("rst_found_re", found, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 4; i++) write_word(32'h200 + 32'(i), i == 3);
    drain(100);
    chk("midrst_pkt_a", if_a.pkt_cnt_o, 16'd1);
    chk("midrst_wcnt_a", if_a.wcnt_o, 16'd0);

    // Random traffic and backpressure against the packet model.
    for (int c = 0; c < 1500; c++) begin
      ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 55) write_word($urandom, $urandom_range(6) == 0);
      step();
    end
    write_word(32'hCAFE_0000, 1'b1);
    drain(100);
    chk("rand_wcnt_a", if_a.wcnt_o, 16'd0);
    chk("rand_wcnt_b", if_b.wcnt_o, 16'd0);
    chk("rand_busy_a", if_a.busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
